// File: rtl/tpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_ctrl_pkg
// Purpose  : Shared control definitions for the systolic matrix unit: FSM
//            state encoding, default array dimension and lane address width.
// Revision : 1.0 - initial release
// ============================================================================
package tpu_ctrl_pkg;

  // Default array dimension (lanes, rows per lane) and lane address width,
  // shared by the read-side controller, write controller and memory wrapper.
  localparam int C_WIDTH_HEIGHT = 16;
  localparam int C_ADDR_W       = 8;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of a counter that must hold 0..2N-2.
  function automatic int step_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wr_lane_gen.sv
`default_nettype none
// ============================================================================
// Module   : wr_lane_gen
// Purpose  : One lane of the output write wavefront. The lane is active for
//            the N steps starting at its own index; its address is the
//            latched base plus the row offset (step - lane), modulo 2^ADDR_W.
// Revision : 1.0 - initial release
// ============================================================================
module wr_lane_gen
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = C_WIDTH_HEIGHT,
  parameter int ADDR_W       = C_ADDR_W,
  parameter int STEP_W       = step_width(C_WIDTH_HEIGHT)
) (
  input  logic              valid,
  input  logic [STEP_W-1:0] step,
  input  logic [STEP_W-1:0] lane_idx,
  input  logic [ADDR_W-1:0] base,
  output logic              lane_en,
  output logic [ADDR_W-1:0] lane_addr
);

  logic [STEP_W-1:0] w_last_step;
  logic [STEP_W-1:0] w_offset;

  // Window test and address; the offset is only used when step >= lane_idx,
  // so the subtraction never underflows where it matters.
  always_comb begin
    w_last_step = lane_idx + STEP_W'(WIDTH_HEIGHT - 1);
    w_offset    = step - lane_idx;
    lane_en     = valid && (step >= lane_idx) && (step <= w_last_step);
    lane_addr   = lane_en ? (base + ADDR_W'(w_offset)) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/wr_control.sv
`default_nettype none
// ============================================================================
// Module   : wr_control
// Purpose  : Output-side write controller. On a start pulse it emits a
//            diagonal wavefront of per-lane write enables and addresses that
//            matches the one-cycle-per-lane skew of the systolic array, then
//            pulses done. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module wr_control
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = C_WIDTH_HEIGHT,
  parameter int ADDR_W       = C_ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic [ADDR_W-1:0]              base_addr,
  output logic [WIDTH_HEIGHT-1:0]        wr_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
  output logic                           busy,
  output logic                           done
);

  localparam int                STEP_W      = step_width(WIDTH_HEIGHT);
  localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(2 * WIDTH_HEIGHT - 2);

  state_t                           r_state;
  state_t                           w_next_state;
  logic [STEP_W-1:0]                r_step;
  logic [STEP_W-1:0]                w_next_step;
  logic [ADDR_W-1:0]                r_base;
  logic [ADDR_W-1:0]                w_next_base;
  logic                             w_lanes_valid;
  logic [WIDTH_HEIGHT-1:0]          w_lane_en;
  logic [WIDTH_HEIGHT*ADDR_W-1:0]   w_lane_addr;

  // State, step counter and latched base address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
      r_base  <= w_next_base;
    end
  end

  // Next-state logic; start requests outside IDLE are dropped, not queued.
  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    w_next_base  = r_base;
    case (r_state)
      ST_IDLE: begin
        if (active) begin
          w_next_state = ST_WRITE;
          w_next_step  = '0;
          w_next_base  = base_addr;
        end
      end
      ST_WRITE: begin
        if (r_step == C_LAST_STEP) begin
          w_next_state = ST_DONE;
          w_next_step  = '0;
        end else begin
          w_next_step = r_step + 1'b1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_step  = '0;
      end
    endcase
  end

  // Lanes are evaluated against the upcoming step so the registered outputs
  // line up with the state they describe (first enable one cycle after start).
  assign w_lanes_valid = (w_next_state == ST_WRITE);

  generate
    for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_lane
      wr_lane_gen #(
        .WIDTH_HEIGHT (WIDTH_HEIGHT),
        .ADDR_W       (ADDR_W),
        .STEP_W       (STEP_W)
      ) u_lane (
        .valid     (w_lanes_valid),
        .step      (w_next_step),
        .lane_idx  (STEP_W'(i)),
        .base      (w_next_base),
        .lane_en   (w_lane_en[i]),
        .lane_addr (w_lane_addr[i*ADDR_W +: ADDR_W])
      );
    end
  endgenerate

  // Output registers; reset clears everything immediately, with no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= '0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en   <= w_lane_en;
      wr_addr <= w_lane_addr;
      busy    <= (w_next_state != ST_IDLE);
      done    <= (w_next_state == ST_DONE);
    end
  end

endmodule
`default_nettype wire
